// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a master and the register-file responder.
// Signal names follow the bus naming used by the surrounding system.
interface axi4_lite_slave_regs_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0]   S_AXI_AWADDR;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [2:0]      S_AXI_AWPROT;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [2:0]      S_AXI_ARPROT;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWPROT,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARPROT,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWPROT,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARPROT,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder with NUM_REGS 32-bit control registers,
// independent write/read FSMs, one outstanding transfer per channel.
module axi4_lite_slave_regs #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS         = 16
) (
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESET,
    axi4_lite_slave_regs_if.slave                s_axi,
    output logic [C_AXI_DATA_WIDTH*NUM_REGS-1:0] REGS_OUT,
    output logic [NUM_REGS-1:0]                  WR_PULSE
);
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wst_t;
    typedef enum logic { R_IDLE, R_DATA } rst_t;

    wst_t                          wst_q;
    rst_t                          rst_q;
    logic [NUM_REGS-1:0][DW-1:0]   regs_q;
    logic [NUM_REGS-1:0]           wr_pulse_q;
    logic                          awready_q, wready_q;
    logic                          aw_held_q, w_held_q;
    logic [AW-1:0]                 awaddr_q;
    logic [DW-1:0]                 wdata_q;
    logic [DW/8-1:0]               wstrb_q;
    logic                          bvalid_q;
    logic [1:0]                    bresp_q;
    logic                          arready_q, rvalid_q;
    logic [DW-1:0]                 rdata_q;
    logic [1:0]                    rresp_q;

    function automatic logic in_range(input logic [AW-1:0] a);
        logic [AW-1:0] idx;
        idx = a >> 2;
        return idx < AW'(NUM_REGS);
    endfunction

    logic            aw_fire, w_fire, aw_h, w_h, w_ok;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic [DW/8-1:0] w_strb;
    logic [IW-1:0]   w_idx;
    logic            ar_fire, ar_ok;
    logic [IW-1:0]   ar_idx;

    // Captured-this-edge beats bypass the holding registers so that
    // a simultaneous AW+W commits in the same cycle.
    assign aw_fire = s_axi.S_AXI_AWVALID && awready_q;
    assign w_fire  = s_axi.S_AXI_WVALID && wready_q;
    assign aw_h    = aw_held_q || aw_fire;
    assign w_h     = w_held_q || w_fire;
    assign w_addr  = aw_fire ? s_axi.S_AXI_AWADDR : awaddr_q;
    assign w_data  = w_fire ? s_axi.S_AXI_WDATA : wdata_q;
    assign w_strb  = w_fire ? s_axi.S_AXI_WSTRB : wstrb_q;
    assign w_idx   = w_addr[IW+1:2];
    assign w_ok    = in_range(w_addr);

    assign ar_fire = s_axi.S_AXI_ARVALID && arready_q;
    assign ar_idx  = s_axi.S_AXI_ARADDR[IW+1:2];
    assign ar_ok   = in_range(s_axi.S_AXI_ARADDR);

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wst_q      <= W_IDLE;
            regs_q     <= '0;
            wr_pulse_q <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
        end else begin
            wr_pulse_q <= '0;
            unique case (wst_q)
                W_IDLE: begin
                    if (aw_fire) awaddr_q <= s_axi.S_AXI_AWADDR;
                    if (w_fire) begin
                        wdata_q <= s_axi.S_AXI_WDATA;
                        wstrb_q <= s_axi.S_AXI_WSTRB;
                    end
                    if (aw_h && w_h) begin
                        if (w_ok) begin
                            for (int b = 0; b < DW/8; b++) begin
                                if (w_strb[b])
                                    regs_q[w_idx][8*b +: 8] <= w_data[8*b +: 8];
                            end
                            wr_pulse_q[w_idx] <= 1'b1;
                        end
                        bresp_q   <= w_ok ? OKAY : SLVERR;
                        bvalid_q  <= 1'b1;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        wst_q     <= W_RESP;
                    end else begin
                        aw_held_q <= aw_h;
                        w_held_q  <= w_h;
                        awready_q <= !aw_h;
                        wready_q  <= !w_h;
                    end
                end
                W_RESP: begin
                    if (bvalid_q && s_axi.S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wst_q     <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Reads sample regs_q before any same-edge write lands.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rst_q     <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            unique case (rst_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        rdata_q   <= ar_ok ? regs_q[ar_idx] : '0;
                        rresp_q   <= ar_ok ? OKAY : SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rst_q     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && s_axi.S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rst_q     <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign REGS_OUT            = regs_q;
    assign WR_PULSE            = wr_pulse_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};
endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs: handshakes, strobes,
// decode errors, backpressure, read/write collision and reset.
module tb_axi4_lite_slave_regs;
    localparam int NR = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_lite_slave_regs_if #(.AW(32), .DW(32)) bus ();
    logic [32*NR-1:0] regs_out;
    logic [NR-1:0]    wr_pulse;

    axi4_lite_slave_regs #(
        .C_AXI_DATA_WIDTH(32),
        .C_AXI_ADDR_WIDTH(32),
        .NUM_REGS(NR)
    ) dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .s_axi       (bus),
        .REGS_OUT    (regs_out),
        .WR_PULSE    (wr_pulse)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [1:0] resp,
                      output logic [NR-1:0] pls);
        bit awp, wp, af, wf;
        int cyc;
        awp = 1; wp = 1; cyc = 0;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        while ((awp || wp) && cyc < 20) begin
            af = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            wf = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            tick();
            cyc++;
            if (af) begin bus.S_AXI_AWVALID = 1'b0; awp = 0; end
            if (wf) begin bus.S_AXI_WVALID = 1'b0; wp = 0; end
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (awp || wp) chk("wr_hs_timeout", 1, 0);
        chk("wr_bvalid_lat", bus.S_AXI_BVALID, 1'b1);
        pls  = wr_pulse;
        resp = bus.S_AXI_BRESP;
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d,
                      output logic [1:0] resp);
        bit f;
        int cyc;
        f = 0; cyc = 0;
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        while (!f && cyc < 20) begin
            f = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
            tick();
            cyc++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        if (!f) chk("rd_hs_timeout", 1, 0);
        chk("rd_rvalid_lat", bus.S_AXI_RVALID, 1'b1);
        d    = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
    endtask

    logic [1:0]       resp;
    logic [NR-1:0]    pls;
    logic [31:0]      rdat;
    logic [32*NR-1:0] exp_regs;
    int               cyc;

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 0; bus.S_AXI_AWPROT = '0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB   = '0; bus.S_AXI_WVALID = 0;
        bus.S_AXI_BREADY = 0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 0; bus.S_AXI_ARPROT = '0;
        bus.S_AXI_RREADY = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl",
            {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
             bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP,
             bus.S_AXI_RRESP, wr_pulse}, '0);
        chk("reset_rdata", bus.S_AXI_RDATA, '0);
        chk("reset_regs", regs_out, '0);
        rst = 1'b0;

        // Test 1: AW and W together
        wr(32'h08, 32'hA5A5_1234, 4'hF, resp, pls);
        chk("t1_bresp", resp, 2'b00);
        chk("t1_pulse", pls, 16'h0004);
        chk("t1_pulse_gone", wr_pulse, '0);
        chk("t1_reg2", regs_out[95:64], 32'hA5A5_1234);

        // Test 2: W first, AW three cycles later
        bus.S_AXI_WDATA  = 32'h0000_00FF;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        cyc = 0;
        while (!bus.S_AXI_WREADY && cyc < 20) begin tick(); cyc++; end
        if (cyc >= 20) chk("t2_wready_timeout", 1, 0);
        tick();
        bus.S_AXI_WVALID = 1'b0;
        chk("t2_wready_low", bus.S_AXI_WREADY, 1'b0);
        chk("t2_awready_high", bus.S_AXI_AWREADY, 1'b1);
        repeat (3) tick();
        chk("t2_no_bvalid", bus.S_AXI_BVALID, 1'b0);
        bus.S_AXI_AWADDR  = 32'h04;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        chk("t2_bvalid", bus.S_AXI_BVALID, 1'b1);
        chk("t2_bresp", bus.S_AXI_BRESP, 2'b00);
        chk("t2_pulse", wr_pulse, 16'h0002);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        rd(32'h04, rdat, resp);
        chk("t2_rdata", rdat, 32'h0000_00FF);
        chk("t2_rresp", resp, 2'b00);

        // Test 3: byte strobes
        wr(32'h00, 32'h1122_3344, 4'hF, resp, pls);
        wr(32'h00, 32'hAABB_CCDD, 4'b0101, resp, pls);
        chk("t3_reg0", regs_out[31:0], 32'h11BB_33DD);
        chk("t3_pulse", pls, 16'h0001);

        // Test 4: out of range, zero strobe, ignored low address bits
        wr(32'h4 * NR, 32'hDEAD_BEEF, 4'hF, resp, pls);
        chk("t4_bresp", resp, 2'b10);
        chk("t4_pulse", pls, '0);
        rd(32'h4 * NR, rdat, resp);
        chk("t4_rdata", rdat, 32'h0);
        chk("t4_rresp", resp, 2'b10);
        wr(32'h08, 32'hFFFF_FFFF, 4'h0, resp, pls);
        chk("t4_strb0_bresp", resp, 2'b00);
        chk("t4_strb0_pulse", pls, 16'h0004);
        exp_regs = '0;
        exp_regs[31:0]  = 32'h11BB_33DD;
        exp_regs[63:32] = 32'h0000_00FF;
        exp_regs[95:64] = 32'hA5A5_1234;
        chk("t4_regs", regs_out, exp_regs);
        rd(32'h0B, rdat, resp);
        chk("t4_lowbits_rdata", rdat, 32'hA5A5_1234);

        // Test 5: collision on reg3 plus backpressure
        wr(32'h0C, 32'h3333_3333, 4'hF, resp, pls);
        bus.S_AXI_AWADDR = 32'h0C; bus.S_AXI_WDATA = 32'h4444_4444;
        bus.S_AXI_WSTRB  = 4'hF;   bus.S_AXI_ARADDR = 32'h0C;
        chk("t5_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                           bus.S_AXI_ARREADY}, 3'b111);
        bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1; bus.S_AXI_ARVALID = 1;
        tick();
        bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_ARVALID = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_ctl", {bus.S_AXI_BVALID, bus.S_AXI_RVALID,
                                bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                                bus.S_AXI_ARREADY}, 5'b11000);
            chk("t5_hold_rdata", {bus.S_AXI_RDATA, bus.S_AXI_RRESP,
                                  bus.S_AXI_BRESP}, {32'h3333_3333, 4'b0});
            tick();
        end
        chk("t5_reg3", regs_out[127:96], 32'h4444_4444);
        bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
        tick();
        bus.S_AXI_BREADY = 0; bus.S_AXI_RREADY = 0;
        chk("t5_single", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        chk("t5_ready_back", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                              bus.S_AXI_ARREADY}, 3'b111);

        // Test 6: reset with both responses pending
        bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1; bus.S_AXI_ARVALID = 1;
        tick();
        bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_ARVALID = 0;
        chk("t6_pending", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        chk("t6_regs", regs_out, '0);
        wr(32'h0C, 32'h1234_5678, 4'hF, resp, pls);
        chk("t6_bresp", resp, 2'b00);
        chk("t6_reg3", regs_out[127:96], 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
